mul_pipe_ctrl: RTL and testbench

Sequencing controller for the multi-cycle multiplier pipeline (banks EX-MUL1 … MEM-MUL4 … MULn). Tracks a valid bit per MUL stage and drives each stage bank's load and reset inputs. Arbitrates the single ROB write port between a completing multiply and the normal WB path, and stalls whichever side loses. Sits beside the main pipeline control, between the issue logic and the ROB.

---
 rtl/mul_pipe_ctrl_if.sv | 38 +++
 rtl/mul_pipe_ctrl.sv | 117 +++++++++++
 tb/tb_mul_pipe_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_pipe_ctrl_if.sv
// mul_pipe_ctrl_if: bundles the issue, ROB-port and bank-control signals
// exchanged between the multiplier sequencing controller and its neighbours.
// The controller connects through the slave modport; the issue logic, WB
// stage, ROB and MUL banks together form the master side.

`ifndef ROB_WIDTH
`define ROB_WIDTH 6
`endif

interface mul_pipe_ctrl_if #(
  parameter int NUM_STAGES = 5
);
  logic                   mul_issue;
  logic                   flush;
  logic                   wb_valid;
  logic [`ROB_WIDTH-1:0]  tag_wb;
  logic [`ROB_WIDTH-1:0]  tag_mul_last;
  logic [NUM_STAGES-1:0]  bank_load;
  logic [NUM_STAGES-1:0]  bank_reset;
  logic [NUM_STAGES-1:0]  mul_valid;
  logic                   issue_stall;
  logic                   wb_stall;
  logic                   rob_wr_en;
  logic                   rob_wr_src;
  logic [`ROB_WIDTH-1:0]  rob_wr_tag;

  modport master (
    output mul_issue, flush, wb_valid, tag_wb, tag_mul_last,
    input  bank_load, bank_reset, mul_valid, issue_stall, wb_stall,
           rob_wr_en, rob_wr_src, rob_wr_tag
  );

  modport slave (
    input  mul_issue, flush, wb_valid, tag_wb, tag_mul_last,
    output bank_load, bank_reset, mul_valid, issue_stall, wb_stall,
           rob_wr_en, rob_wr_src, rob_wr_tag
  );
endinterface

// File: rtl/mul_pipe_ctrl.sv
// mul_pipe_ctrl: sequencing controller for the multi-cycle multiplier
// pipeline. Tracks one valid bit per MUL stage, drives the stage banks' load
// and clear inputs, and arbitrates the single ROB write port between a
// completing multiply and the normal WB path.
//
// Optional feature: define MUL_STARVE_GUARD_EN to enable the WB starvation
// guard. After STARVE_LIMIT consecutive WB stalls the WB result wins the ROB
// port and the MUL pipeline freezes for that one cycle. Without the macro the
// multiply path always wins and the pipeline never freezes.

`ifndef ROB_WIDTH
`define ROB_WIDTH 6
`endif

module mul_pipe_ctrl #(
  parameter int NUM_STAGES   = 5,
  parameter int STARVE_LIMIT = 3
) (
  input logic             clk,
  input logic             reset,
  mul_pipe_ctrl_if.slave  bus
);

  // Reject illegal configurations at elaboration time.
  if (NUM_STAGES < 2 || NUM_STAGES > 8) begin : g_bad_num_stages
    $error("mul_pipe_ctrl: NUM_STAGES must be 2..8");
  end
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
    $error("mul_pipe_ctrl: STARVE_LIMIT must be 1..15");
  end

  logic [NUM_STAGES-1:0]  mul_valid_q;
  logic                   mul_done;
  logic                   freeze;
  logic                   advance;
  logic [NUM_STAGES-1:0]  bank_load;
  logic [NUM_STAGES-1:0]  bank_reset;
  logic                   issue_stall;
  logic                   wb_stall;
  logic                   rob_wr_en;
  logic                   rob_wr_src;
  logic [`ROB_WIDTH-1:0]  rob_wr_tag;

  assign mul_done = mul_valid_q[NUM_STAGES-1];
  assign advance  = ~freeze;

`ifdef MUL_STARVE_GUARD_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;

  // WB forces its way in once it has been stalled LIMIT times in a row;
  // flush kills everything that cycle, so no forced grant then.
  assign freeze = bus.wb_valid & ~bus.flush & (starve_cnt == LIMIT);

  // Count consecutive WB stalls; any non-stall cycle, flush or reset restarts the count.
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      starve_cnt <= '0;
    end else if (wb_stall) begin
      starve_cnt <= (starve_cnt == 4'hF) ? starve_cnt : starve_cnt + 4'd1;
    end else begin
      starve_cnt <= '0;
    end
  end
`else
  assign freeze = 1'b0;
`endif

  // Shift the per-stage valid bits forward unless frozen; flush/reset empty the pipe.
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      mul_valid_q <= '0;
    end else if (advance) begin
      mul_valid_q <= {mul_valid_q[NUM_STAGES-2:0], bus.mul_issue};
    end
  end

  // Bank control and ROB port arbitration; flush overrides everything.
  always_comb begin
    bank_load     = {NUM_STAGES{advance}};
    bank_reset    = '0;
    bank_reset[0] = advance & ~bus.mul_issue;
    issue_stall   = freeze & bus.mul_issue;
    rob_wr_en     = 1'b0;
    rob_wr_src    = 1'b0;
    rob_wr_tag    = bus.tag_wb;
    wb_stall      = 1'b0;
    if (freeze) begin
      rob_wr_en = 1'b1;
    end else if (mul_done) begin
      rob_wr_en  = 1'b1;
      rob_wr_src = 1'b1;
      rob_wr_tag = bus.tag_mul_last;
      wb_stall   = bus.wb_valid;
    end else if (bus.wb_valid) begin
      rob_wr_en = 1'b1;
    end
    if (bus.flush) begin
      bank_load   = '0;
      bank_reset  = '1;
      issue_stall = 1'b0;
      rob_wr_en   = 1'b0;
      wb_stall    = 1'b0;
    end
  end

  assign bus.mul_valid   = mul_valid_q;
  assign bus.bank_load   = bank_load;
  assign bus.bank_reset  = bank_reset;
  assign bus.issue_stall = issue_stall;
  assign bus.wb_stall    = wb_stall;
  assign bus.rob_wr_en   = rob_wr_en;
  assign bus.rob_wr_src  = rob_wr_src;
  assign bus.rob_wr_tag  = rob_wr_tag;

endmodule

// File: tb/tb_mul_pipe_ctrl.sv
// tb_mul_pipe_ctrl: self-checking bench for mul_pipe_ctrl. Models the MUL
// bank tag registers so tag_mul_last follows the issued tags, and keeps a
// scoreboard of expected multiply completions (cycle and tag).

`ifndef ROB_WIDTH
`define ROB_WIDTH 6
`endif

module tb_mul_pipe_ctrl;
  localparam int N     = 5;
  localparam int LIMIT = 3;
  localparam int TW    = `ROB_WIDTH;
  localparam logic [N-1:0] ALL_ONES = '1;
  localparam logic [N-1:0] ZEROS    = '0;
  localparam logic [N-1:0] ONE_HOT0 = N'(1);

  typedef struct {
    int            cyc;
    logic [TW-1:0] tag;
  } exp_t;

  logic          clk;
  logic          reset;
  int            cyc = 0;
  int            checks = 0;
  int            fails = 0;
  logic [TW-1:0] issue_tag;
  logic [TW-1:0] tag_pipe [N];
  exp_t          sb[$];

  mul_pipe_ctrl_if #(.NUM_STAGES(N)) bus ();

  mul_pipe_ctrl #(.NUM_STAGES(N), .STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Period index: incremented at every rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Tag registers of the MUL banks, loaded/cleared by the controller.
  always @(posedge clk) begin
    if (bus.bank_reset[0]) tag_pipe[0] <= '0;
    else if (bus.bank_load[0]) tag_pipe[0] <= issue_tag;
    for (int i = 1; i < N; i++) begin
      if (bus.bank_reset[i]) tag_pipe[i] <= '0;
      else if (bus.bank_load[i]) tag_pipe[i] <= tag_pipe[i-1];
    end
  end
  assign bus.tag_mul_last = tag_pipe[N-1];

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) next_cycle();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mul_valid !== ZEROS) begin fails++; $display("[TB] FAIL reset_mul_valid: got %b expected %b", bus.mul_valid, ZEROS); end
    checks++;
    if (bus.bank_load !== ALL_ONES) begin fails++; $display("[TB] FAIL reset_bank_load: got %b expected %b", bus.bank_load, ALL_ONES); end
    checks++;
    if (bus.bank_reset !== ONE_HOT0) begin fails++; $display("[TB] FAIL reset_bank_reset: got %b expected %b", bus.bank_reset, ONE_HOT0); end
    checks++;
    if (bus.rob_wr_en !== 1'b0 || bus.issue_stall !== 1'b0 || bus.wb_stall !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_strobes: got en=%b istall=%b wstall=%b expected 0 0 0", bus.rob_wr_en, bus.issue_stall, bus.wb_stall);
    end
    next_cycle();
    bus.wb_valid = 1'b1;
    bus.tag_wb   = TW'(9);
    @(negedge clk);
    checks++;
    if (bus.rob_wr_en !== 1'b1 || bus.rob_wr_src !== 1'b0 || bus.rob_wr_tag !== TW'(9) || bus.wb_stall !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_wb_write: got en=%b src=%b tag=%0d stall=%b expected 1 0 9 0", bus.rob_wr_en, bus.rob_wr_src, bus.rob_wr_tag, bus.wb_stall);
    end
    next_cycle();
    bus.wb_valid = 1'b0;
  endtask

  task automatic test_single_issue();
    logic [N-1:0] exp_mv;
    logic [N-1:0] exp_br;
    exp_t e;
    for (int j = 0; j <= N + 1; j++) begin
      bus.mul_issue = (j == 0);
      issue_tag     = TW'(21);
      if (j == 0) begin e.cyc = cyc + N; e.tag = TW'(21); sb.push_back(e); end
      @(negedge clk);
      exp_mv = '0;
      if (j >= 1 && j <= N) exp_mv = ONE_HOT0 << (j - 1);
      exp_br = (j == 0) ? ZEROS : ONE_HOT0;
      checks++;
      if (bus.mul_valid !== exp_mv) begin fails++; $display("[TB] FAIL single_mul_valid j=%0d: got %b expected %b", j, bus.mul_valid, exp_mv); end
      checks++;
      if (bus.bank_reset !== exp_br || bus.bank_load !== ALL_ONES) begin
        fails++; $display("[TB] FAIL single_bank_ctrl j=%0d: got reset=%b load=%b expected %b %b", j, bus.bank_reset, bus.bank_load, exp_br, ALL_ONES);
      end
      checks++;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        if (bus.rob_wr_en !== 1'b1 || bus.rob_wr_src !== 1'b1 || bus.rob_wr_tag !== sb[0].tag) begin
          fails++; $display("[TB] FAIL single_mul_write j=%0d: got en=%b src=%b tag=%0d expected 1 1 %0d", j, bus.rob_wr_en, bus.rob_wr_src, bus.rob_wr_tag, sb[0].tag);
        end
        void'(sb.pop_front());
      end else if ((bus.rob_wr_en & bus.rob_wr_src) !== 1'b0) begin
        fails++; $display("[TB] FAIL single_spurious_write j=%0d: got en=%b src=%b expected no MUL write", j, bus.rob_wr_en, bus.rob_wr_src);
      end
      next_cycle();
    end
    bus.mul_issue = 1'b0;
    checks++;
    if (sb.size() != 0) begin fails++; $display("[TB] FAIL single_drain: got %0d pending expected 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_collision();
    exp_t e;
    for (int j = 0; j <= N + 1; j++) begin
      bus.mul_issue = (j == 0);
      issue_tag     = TW'(3);
      bus.wb_valid  = (j >= N);
      bus.tag_wb    = TW'(7);
      if (j == 0) begin e.cyc = cyc + N; e.tag = TW'(3); sb.push_back(e); end
      @(negedge clk);
      checks++;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        if (bus.rob_wr_en !== 1'b1 || bus.rob_wr_src !== 1'b1 || bus.rob_wr_tag !== sb[0].tag || bus.wb_stall !== 1'b1) begin
          fails++; $display("[TB] FAIL collide_mul_wins: got en=%b src=%b tag=%0d wstall=%b expected 1 1 %0d 1", bus.rob_wr_en, bus.rob_wr_src, bus.rob_wr_tag, bus.wb_stall, sb[0].tag);
        end
        void'(sb.pop_front());
      end else if ((bus.rob_wr_en & bus.rob_wr_src) !== 1'b0) begin
        fails++; $display("[TB] FAIL collide_spurious_write j=%0d: got en=%b src=%b expected no MUL write", j, bus.rob_wr_en, bus.rob_wr_src);
      end
      if (j == N + 1) begin
        checks++;
        if (bus.rob_wr_en !== 1'b1 || bus.rob_wr_src !== 1'b0 || bus.rob_wr_tag !== TW'(7) || bus.wb_stall !== 1'b0) begin
          fails++; $display("[TB] FAIL collide_wb_retry: got en=%b src=%b tag=%0d wstall=%b expected 1 0 7 0", bus.rob_wr_en, bus.rob_wr_src, bus.rob_wr_tag, bus.wb_stall);
        end
      end
      next_cycle();
    end
    bus.mul_issue = 1'b0;
    bus.wb_valid  = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int j = 0; j <= N + 5; j++) begin
      bus.mul_issue = (j < 5);
      issue_tag     = TW'(10 + j);
      if (j < 5) begin e.cyc = cyc + N; e.tag = TW'(10 + j); sb.push_back(e); end
      @(negedge clk);
      checks++;
      if (bus.issue_stall !== 1'b0) begin fails++; $display("[TB] FAIL b2b_issue_stall j=%0d: got %b expected 0", j, bus.issue_stall); end
      if (j == N) begin
        checks++;
        if (bus.mul_valid !== ALL_ONES) begin fails++; $display("[TB] FAIL b2b_peak: got %b expected %b", bus.mul_valid, ALL_ONES); end
      end
      checks++;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        if (bus.rob_wr_en !== 1'b1 || bus.rob_wr_src !== 1'b1 || bus.rob_wr_tag !== sb[0].tag) begin
          fails++; $display("[TB] FAIL b2b_mul_write j=%0d: got en=%b src=%b tag=%0d expected 1 1 %0d", j, bus.rob_wr_en, bus.rob_wr_src, bus.rob_wr_tag, sb[0].tag);
        end
        void'(sb.pop_front());
      end else if ((bus.rob_wr_en & bus.rob_wr_src) !== 1'b0) begin
        fails++; $display("[TB] FAIL b2b_spurious_write j=%0d: got en=%b src=%b expected no MUL write", j, bus.rob_wr_en, bus.rob_wr_src);
      end
      next_cycle();
    end
    bus.mul_issue = 1'b0;
    checks++;
    if (sb.size() != 0) begin fails++; $display("[TB] FAIL b2b_drain: got %0d pending expected 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_flush();
    logic [N-1:0] exp_mv;
    exp_mv = 5'b10110;
    for (int j = 0; j <= 5; j++) begin
      bus.mul_issue = (j == 0 || j == 2 || j == 3 || j == 5);
      bus.flush     = (j == 5);
      bus.wb_valid  = (j == 5);
      bus.tag_wb    = TW'(5);
      @(negedge clk);
      if (j < 5) begin
        checks++;
        if (bus.rob_wr_en !== 1'b0) begin fails++; $display("[TB] FAIL flush_prefill_write j=%0d: got %b expected 0", j, bus.rob_wr_en); end
      end else begin
        checks++;
        if (bus.mul_valid !== exp_mv) begin fails++; $display("[TB] FAIL flush_pre_valid: got %b expected %b", bus.mul_valid, exp_mv); end
        checks++;
        if (bus.bank_reset !== ALL_ONES || bus.bank_load !== ZEROS) begin
          fails++; $display("[TB] FAIL flush_banks: got reset=%b load=%b expected %b %b", bus.bank_reset, bus.bank_load, ALL_ONES, ZEROS);
        end
        checks++;
        if (bus.rob_wr_en !== 1'b0 || bus.issue_stall !== 1'b0 || bus.wb_stall !== 1'b0) begin
          fails++; $display("[TB] FAIL flush_strobes: got en=%b istall=%b wstall=%b expected 0 0 0", bus.rob_wr_en, bus.issue_stall, bus.wb_stall);
        end
      end
      next_cycle();
    end
    bus.mul_issue = 1'b0;
    bus.flush     = 1'b0;
    bus.wb_valid  = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.mul_valid !== ZEROS) begin fails++; $display("[TB] FAIL flush_post_valid: got %b expected %b", bus.mul_valid, ZEROS); end
    checks++;
    if (bus.rob_wr_en !== 1'b1 || bus.rob_wr_src !== 1'b0) begin fails++; $display("[TB] FAIL flush_post_wb: got en=%b src=%b expected 1 0", bus.rob_wr_en, bus.rob_wr_src); end
    next_cycle();
    bus.wb_valid = 1'b0;
    for (int j = 0; j < N; j++) begin
      @(negedge clk);
      checks++;
      if (bus.rob_wr_en !== 1'b0) begin fails++; $display("[TB] FAIL flush_leftover j=%0d: got en=%b expected 0", j, bus.rob_wr_en); end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] exp_mv;
    exp_mv = 5'b01100;
    for (int j = 0; j <= 4; j++) begin
      bus.mul_issue = (j <= 1);
      reset         = (j == 4);
      @(negedge clk);
      if (j == 4) begin
        checks++;
        if (bus.mul_valid !== exp_mv) begin fails++; $display("[TB] FAIL rstmid_pre_valid: got %b expected %b", bus.mul_valid, exp_mv); end
      end
      next_cycle();
    end
    reset         = 1'b0;
    bus.mul_issue = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mul_valid !== ZEROS) begin fails++; $display("[TB] FAIL rstmid_post_valid: got %b expected %b", bus.mul_valid, ZEROS); end
    for (int j = 0; j < N; j++) begin
      checks++;
      if (bus.rob_wr_en !== 1'b0 || bus.wb_stall !== 1'b0) begin
        fails++; $display("[TB] FAIL rstmid_no_write j=%0d: got en=%b wstall=%b expected 0 0", j, bus.rob_wr_en, bus.wb_stall);
      end
      next_cycle();
      @(negedge clk);
    end
    next_cycle();
  endtask

  task automatic test_arbitration_pressure();
    for (int j = 0; j <= N + 7; j++) begin
      bus.mul_issue = 1'b1;
      bus.wb_valid  = (j >= N);
      bus.tag_wb    = TW'(7);
      @(negedge clk);
      if (j >= N) begin
`ifdef MUL_STARVE_GUARD_EN
        if ((j - N) % (LIMIT + 1) == LIMIT) begin
          checks++;
          if (bus.rob_wr_en !== 1'b1 || bus.rob_wr_src !== 1'b0 || bus.rob_wr_tag !== TW'(7) || bus.wb_stall !== 1'b0) begin
            fails++; $display("[TB] FAIL guard_wb_wins j=%0d: got en=%b src=%b tag=%0d wstall=%b expected 1 0 7 0", j, bus.rob_wr_en, bus.rob_wr_src, bus.rob_wr_tag, bus.wb_stall);
          end
          checks++;
          if (bus.bank_load !== ZEROS || bus.issue_stall !== 1'b1 || bus.mul_valid !== ALL_ONES) begin
            fails++; $display("[TB] FAIL guard_freeze j=%0d: got load=%b istall=%b valid=%b expected %b 1 %b", j, bus.bank_load, bus.issue_stall, bus.mul_valid, ZEROS, ALL_ONES);
          end
        end else begin
          checks++;
          if (bus.wb_stall !== 1'b1 || bus.rob_wr_src !== 1'b1 || bus.mul_valid !== ALL_ONES || bus.issue_stall !== 1'b0) begin
            fails++; $display("[TB] FAIL guard_mul_wins j=%0d: got wstall=%b src=%b valid=%b istall=%b expected 1 1 %b 0", j, bus.wb_stall, bus.rob_wr_src, bus.mul_valid, bus.issue_stall, ALL_ONES);
          end
        end
`else
        checks++;
        if (bus.wb_stall !== 1'b1 || bus.rob_wr_en !== 1'b1 || bus.rob_wr_src !== 1'b1) begin
          fails++; $display("[TB] FAIL prio_mul_wins j=%0d: got wstall=%b en=%b src=%b expected 1 1 1", j, bus.wb_stall, bus.rob_wr_en, bus.rob_wr_src);
        end
        checks++;
        if (bus.issue_stall !== 1'b0 || bus.bank_load !== ALL_ONES) begin
          fails++; $display("[TB] FAIL prio_no_freeze j=%0d: got istall=%b load=%b expected 0 %b", j, bus.issue_stall, bus.bank_load, ALL_ONES);
        end
`endif
      end
      next_cycle();
    end
    bus.mul_issue = 1'b0;
    bus.wb_valid  = 1'b0;
    bus.flush     = 1'b1;
    next_cycle();
    bus.flush     = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mul_valid !== ZEROS) begin fails++; $display("[TB] FAIL pressure_cleanup: got %b expected %b", bus.mul_valid, ZEROS); end
    next_cycle();
  endtask

  initial begin
    reset         = 1'b1;
    bus.mul_issue = 1'b0;
    bus.flush     = 1'b0;
    bus.wb_valid  = 1'b0;
    bus.tag_wb    = '0;
    issue_tag     = '0;
    test_reset();
    test_single_issue();
    test_collision();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_arbitration_pressure();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
